// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch with credit-limited imem requests, PC-tagged FIFO and redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic stop_q, stop_d;
  logic [31:0] inst_q [FIFO_DEPTH];
  logic [31:0] epc_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] flt_q;
  logic [CW:0] credit;
  logic [31:0] new_pc;
  logic issue, rsp, push, pop;
  always_comb begin
    credit    = {1'b0, out_q} + {1'b0, cnt_q};
    new_pc    = {redirect_pc[31:2], 2'b00};
    imem_req  = !rst && !redirect_valid && !stop_q && (credit < DEPTH);
    imem_addr = pc_q;
    id_valid  = !rst && (cnt_q != '0) && !redirect_valid;
    id_pc     = id_valid ? epc_q[rd_q] : '0;
    id_fault  = id_valid && flt_q[rd_q];
    id_inst   = (id_valid && !flt_q[rd_q]) ? inst_q[rd_q] : NOP;
    issue     = imem_req && imem_gnt;
    rsp       = imem_rvalid && (out_q != '0);
    push      = rsp && (disc_q == '0) && !redirect_valid;
    pop       = id_valid && id_ready;
    pc_d      = redirect_valid ? new_pc : issue ? pc_q + 32'd4 : pc_q;
    rsp_pc_d  = redirect_valid ? new_pc : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    out_d     = out_q + CW'(issue) - CW'(rsp);
    disc_d    = redirect_valid ? out_q - CW'(rsp) : disc_q - CW'(rsp && (disc_q != '0));
    stop_d    = !redirect_valid && (stop_q || (push && imem_err));
    cnt_d     = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d      = redirect_valid ? '0 : rd_q + AW'(pop);
    wr_d      = redirect_valid ? '0 : wr_q + AW'(push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      stop_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      stop_q   <= stop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) assert ({1'b0, cnt_q} < DEPTH);
    if (push) begin
      inst_q[wr_q] <= imem_rdata;
      epc_q[wr_q]  <= rsp_pc_q;
      flt_q[wr_q]  <= imem_err;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle-by-cycle directed vectors for fetch_stage plus a streaming order check
module tb_fetch_stage;
  logic        clk = 0, rst = 1, redirect_valid = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic        imem_gnt = 0, imem_rvalid = 0, imem_err = 0, id_ready = 0;
  logic        imem_req, id_valid, id_fault;
  logic [31:0] imem_addr, id_inst, id_pc;
  int passed = 0, total = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, rv; logic [31:0] rpc;
    logic g, rvl; logic [31:0] ra; logic er, rdy;
    logic eq; logic [31:0] ea; logic ev; logic [31:0] ep; logic ef;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // columns: rst redirect rpc | gnt rvalid resp_addr err ready | exp req addr valid pc fault
  task automatic v(input logic r, rv, input logic [31:0] rpc, input logic g, rvl,
                   input logic [31:0] ra, input logic er, rdy, eq, input logic [31:0] ea,
                   input logic ev, input logic [31:0] ep, input logic ef);
    vq.push_back('{r, rv, rpc, g, rvl, ra, er, rdy, eq, ea, ev, ep, ef});
  endtask

  initial begin
    logic [31:0] next_exp, rsp_addr;
    logic pend;
    int got;
    v(1,0,0,     1,0,0,0,1,       0,0,       0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h0,     0,0,0);
    v(0,0,0,     1,1,'h0,0,1,     1,'h4,     0,0,0);
    v(0,0,0,     1,1,'h4,0,1,     0,0,       1,'h0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h8,     1,'h4,0);
    v(0,0,0,     1,1,'h8,0,1,     1,'hC,     0,0,0);
    v(0,0,0,     1,1,'hC,0,1,     0,0,       1,'h8,0);
    v(0,0,0,     1,0,0,0,1,       1,'h10,    1,'hC,0);
    v(0,0,0,     1,1,'h10,0,0,    1,'h14,    0,0,0);
    v(0,0,0,     1,1,'h14,0,0,    0,0,       1,'h10,0);
    v(0,0,0,     1,0,0,0,0,       0,0,       1,'h10,0);
    v(0,0,0,     1,0,0,0,0,       0,0,       1,'h10,0);
    v(0,0,0,     1,0,0,0,0,       0,0,       1,'h10,0);
    v(0,0,0,     1,0,0,0,1,       0,0,       1,'h10,0);
    v(0,0,0,     1,0,0,0,1,       1,'h18,    1,'h14,0);
    v(0,0,0,     0,1,'h18,0,1,    1,'h1C,    0,0,0);
    v(0,0,0,     0,0,0,0,0,       1,'h1C,    1,'h18,0);
    v(0,0,0,     1,0,0,0,1,       1,'h1C,    1,'h18,0);
    v(0,0,0,     1,0,0,0,1,       1,'h20,    0,0,0);
    v(0,1,'h103, 1,0,0,0,1,       0,0,       0,0,0);
    v(0,0,0,     1,1,'h1C,0,1,    0,0,       0,0,0);
    v(0,0,0,     1,1,'h20,0,1,    1,'h100,   0,0,0);
    v(0,0,0,     0,1,'h100,0,1,   1,'h104,   0,0,0);
    v(0,0,0,     0,0,0,0,1,       1,'h104,   1,'h100,0);
    v(0,0,0,     1,0,0,0,0,       1,'h104,   0,0,0);
    v(0,0,0,     1,0,0,0,0,       1,'h108,   0,0,0);
    v(0,0,0,     1,1,'h104,0,0,   0,0,       0,0,0);
    v(0,1,'h40,  1,1,'h108,0,1,   0,0,       0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h40,    0,0,0);
    v(0,0,0,     0,1,'h40,0,1,    1,'h44,    0,0,0);
    v(0,0,0,     0,0,0,0,1,       1,'h44,    1,'h40,0);
    v(0,0,0,     1,0,0,0,1,       1,'h44,    0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h48,    0,0,0);
    v(0,1,'h80,  1,1,'h44,0,1,    0,0,       0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h80,    0,0,0);
    v(0,0,0,     1,1,'h48,0,1,    0,0,       0,0,0);
    v(0,0,0,     1,1,'h80,0,1,    1,'h84,    0,0,0);
    v(0,0,0,     1,1,'h84,0,1,    0,0,       1,'h80,0);
    v(0,0,0,     0,0,0,0,1,       1,'h88,    1,'h84,0);
    v(0,1,'h8,   0,0,0,0,1,       0,0,       0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h8,     0,0,0);
    v(0,0,0,     1,1,'h8,1,1,     1,'hC,     0,0,0);
    v(0,0,0,     1,1,'hC,0,0,     0,0,       1,'h8,1);
    v(0,0,0,     1,0,0,0,1,       0,0,       1,'h8,1);
    v(0,0,0,     1,0,0,0,1,       0,0,       1,'hC,0);
    v(0,0,0,     1,0,0,0,1,       0,0,       0,0,0);
    v(0,1,'h200, 1,0,0,0,1,       0,0,       0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h200,   0,0,0);
    v(0,0,0,     0,1,'h200,0,1,   1,'h204,   0,0,0);
    v(0,0,0,     0,0,0,0,1,       1,'h204,   1,'h200,0);
    v(0,1,'hFFFF_FFFE, 1,0,0,0,1, 0,0,       0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'hFFFF_FFFC, 0,0,0);
    v(0,0,0,     1,1,'hFFFF_FFFC,0,1, 1,'h0, 0,0,0);
    v(0,0,0,     1,1,'h0,0,1,     0,0,       1,'hFFFF_FFFC,0);
    v(0,0,0,     1,0,0,0,0,       1,'h4,     1,'h0,0);
    v(1,0,0,     1,0,0,0,1,       0,0,       0,0,0);
    v(0,0,0,     0,0,0,0,1,       1,'h0,     0,0,0);
    v(0,0,0,     1,0,0,0,1,       1,'h0,     0,0,0);
    v(0,0,0,     0,1,'h0,0,1,     1,'h4,     0,0,0);
    v(0,0,0,     0,0,0,0,1,       1,'h4,     1,'h0,0);
    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r; redirect_valid = vq[i].rv; redirect_pc = vq[i].rpc;
      imem_gnt = vq[i].g; imem_rvalid = vq[i].rvl; imem_rdata = inst_of(vq[i].ra);
      imem_err = vq[i].er; id_ready = vq[i].rdy;
      #1;
      chk($sformatf("row%0d req", i), imem_req, vq[i].eq);
      if (vq[i].eq) chk($sformatf("row%0d addr", i), imem_addr, vq[i].ea);
      chk($sformatf("row%0d valid", i), id_valid, vq[i].ev);
      chk($sformatf("row%0d inst", i), id_inst,
          (vq[i].ev && !vq[i].ef) ? inst_of(vq[i].ep) : 32'h0000_0013);
      if (vq[i].ev || vq[i].r) chk($sformatf("row%0d pc", i), id_pc, vq[i].ep);
      chk($sformatf("row%0d fault", i), id_fault, vq[i].ev && vq[i].ef);
    end
    // reset wins over a simultaneous redirect
    @(negedge clk);
    rst = 1; redirect_valid = 1; redirect_pc = 32'h300; imem_gnt = 0; imem_rvalid = 0; imem_err = 0;
    #1;
    chk("rst_redir req", imem_req, 0);
    chk("rst_redir valid", id_valid, 0);
    @(negedge clk);
    rst = 0; redirect_valid = 0;
    #1;
    chk("rst_redir req_after", imem_req, 1);
    chk("rst_redir addr", imem_addr, 32'h0);
    // free-running memory with one-cycle response latency
    next_exp = 0; rsp_addr = 0; pend = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      imem_gnt = 1; id_ready = 1; imem_err = 0;
      imem_rvalid = pend; imem_rdata = inst_of(rsp_addr);
      #1;
      if (imem_req) chk("stream ahead", {31'b0, (imem_addr - next_exp) <= 32'd8}, 1);
      if (id_valid) begin
        chk("stream pc", id_pc, next_exp);
        chk("stream inst", id_inst, inst_of(next_exp));
        next_exp += 4;
        got++;
      end
      pend = imem_req && imem_gnt;
      if (pend) rsp_addr = imem_addr;
    end
    chk("stream delivered", got, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
